// File: rtl/data_mem_ctr_if.sv
// data_mem_ctr_if: memory-access stage <-> data-memory controller request/response bundle.
interface data_mem_ctr_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_val;
    logic        i_op;
    logic [2:0]  i_func_3;
    logic [31:0] val_from_mem_ctr;
    logic        stall;
    logic        access_fault;

    // Pipeline side: issues requests, consumes load data and stall/fault
    modport master (
        output i_req, i_addr, i_val, i_op, i_func_3,
        input  val_from_mem_ctr, stall, access_fault
    );

    // Controller side
    modport slave (
        input  i_req, i_addr, i_val, i_op, i_func_3,
        output val_from_mem_ctr, stall, access_fault
    );
endinterface

// File: rtl/data_mem_ctr.sv
// data_mem_ctr: load/store controller with a word-organised RAM and fixed access latency.
// Optional feature macro DATA_MEM_CTR_POSTED_STORE_EN: legal stores are posted into a
// one-entry write buffer and drained in the background (WBUF state).
module data_mem_ctr #(
    parameter int unsigned MEM_WORDS = 1024,
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned LATENCY   = 2
) (
    input  logic          clk,
    input  logic          reset,
    data_mem_ctr_if.slave bus
);
    localparam int unsigned CNT_W = 4;
    localparam int unsigned DW    = 32;

`ifdef DATA_MEM_CTR_POSTED_STORE_EN
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2, WBUF = 2'd3} state_e;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_e;
`endif

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] widx_q, widx_d;
    logic [1:0]        lane_q, lane_d;
    logic              op_q, op_d;
    logic [2:0]        func_3_q, func_3_d;
    logic [DW-1:0]     wval_q, wval_d;
    logic [DW-1:0]     rdata_q, rdata_d;

    logic [DW-1:0]     mem [MEM_WORDS];

    logic              size_ok_c;
    logic              align_ok_c;
    logic              legal_c;
    logic              stall_c;
    logic              fault_c;
    logic              mem_we_c;
    logic [3:0]        be_c;
    logic [DW-1:0]     wdata_c;
    logic [DW-1:0]     rword_c;
    logic [DW-1:0]     rshift_c;
    logic [DW-1:0]     load_c;
    logic              unused_addr_c;

    // Upper address bits are ignored so accesses wrap modulo MEM_WORDS
    assign unused_addr_c = ^bus.i_addr[DW-1:ADDR_W+2];

    // Classify the incoming request as supported and naturally aligned
    always_comb begin
        size_ok_c  = 1'b0;
        align_ok_c = 1'b0;
        if (bus.i_op) begin
            size_ok_c = (bus.i_func_3 <= 3'b010);
        end else begin
            size_ok_c = (bus.i_func_3 != 3'b011) && (bus.i_func_3 < 3'b110);
        end
        case (bus.i_func_3[1:0])
            2'b00:   align_ok_c = 1'b1;
            2'b01:   align_ok_c = ~bus.i_addr[0];
            2'b10:   align_ok_c = (bus.i_addr[1:0] == 2'b00);
            default: align_ok_c = 1'b0;
        endcase
        legal_c = size_ok_c & align_ok_c;
    end

    // Lane steering for the latched access: store byte enables/data and load extract
    always_comb begin
        be_c = 4'b1111;
        case (func_3_q[1:0])
            2'b00:   be_c = 4'b0001 << lane_q;
            2'b01:   be_c = 4'b0011 << lane_q;
            default: be_c = 4'b1111;
        endcase
        wdata_c  = wval_q << {lane_q, 3'b000};
        rword_c  = mem[widx_q];
        rshift_c = rword_c >> {lane_q, 3'b000};
        load_c   = rshift_c;
        case (func_3_q[1:0])
            2'b00:   load_c = {24'd0, rshift_c[7:0]};
            2'b01:   load_c = {16'd0, rshift_c[15:0]};
            default: load_c = rshift_c;
        endcase
    end

    // Next-state, latch and output decode
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        widx_d   = widx_q;
        lane_d   = lane_q;
        op_d     = op_q;
        func_3_d = func_3_q;
        wval_d   = wval_q;
        rdata_d  = rdata_q;
        stall_c  = 1'b0;
        fault_c  = 1'b0;
        mem_we_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.i_req) begin
                    if (legal_c) begin
                        widx_d   = bus.i_addr[ADDR_W+1:2];
                        lane_d   = bus.i_addr[1:0];
                        op_d     = bus.i_op;
                        func_3_d = bus.i_func_3;
                        wval_d   = bus.i_val;
                        cnt_d    = CNT_W'(LATENCY - 1);
`ifdef DATA_MEM_CTR_POSTED_STORE_EN
                        if (bus.i_op) begin
                            state_d = WBUF;
                        end else begin
                            stall_c = 1'b1;
                            state_d = BUSY;
                        end
`else
                        stall_c = 1'b1;
                        state_d = BUSY;
`endif
                    end else begin
                        fault_c = 1'b1;
                        rdata_d = '0;
                    end
                end
            end
            BUSY: begin
                stall_c = 1'b1;
                if (cnt_q == '0) begin
                    if (op_q) begin
                        mem_we_c = 1'b1;
                    end else begin
                        rdata_d = load_c;
                    end
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
`ifdef DATA_MEM_CTR_POSTED_STORE_EN
            WBUF: begin
                // Buffered store drains; any new request waits for IDLE
                stall_c = bus.i_req;
                if (cnt_q == '0) begin
                    mem_we_c = 1'b1;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and request latch registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            widx_q   <= '0;
            lane_q   <= '0;
            op_q     <= 1'b0;
            func_3_q <= '0;
            wval_q   <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            widx_q   <= widx_d;
            lane_q   <= lane_d;
            op_q     <= op_d;
            func_3_q <= func_3_d;
            wval_q   <= wval_d;
            rdata_q  <= rdata_d;
        end
    end

    // RAM byte-enabled write; reset discards a pending store
    always_ff @(posedge clk) begin
        if (mem_we_c && !reset) begin
            for (int b = 0; b < 4; b++) begin
                if (be_c[b]) begin
                    mem[widx_q][8*b +: 8] <= wdata_c[8*b +: 8];
                end
            end
        end
    end

    // Stall and fault are request-cycle signals, forced low while reset is asserted
    assign bus.val_from_mem_ctr = rdata_q;
    assign bus.stall            = stall_c & ~reset;
    assign bus.access_fault     = fault_c & ~reset;

endmodule
